// File: rtl/uart_pkg.sv
// Shared UART types and constants: frame state encoding and the ASCII codes used by the streamer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // NUL bytes would be invisible on a terminal, so they go out as spaces
    function automatic logic [7:0] nul_to_space(input logic [7:0] b);
        return (b == 8'h00) ? ASCII_SPACE : b;
    endfunction

endpackage

// File: rtl/char_uart_streamer_if.sv
// Bundle between the ARM top level and the character streamer: dump request, array and UART status.
interface char_uart_streamer_if #(
    parameter int unsigned NUM_CHARS = 64
);
    logic       start;
    logic [7:0] charArray [NUM_CHARS];
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output start, charArray, input tx, busy, done);
    modport slave  (input start, charArray, output tx, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for one byte per handshake; accepts the next byte in the last stop-bit
// cycle so consecutive frames have no idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_e   state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_q, tx_n;
    logic          baud_wrap;

    assign baud_wrap = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx        = tx_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            tx_q     <= tx_n;
        end
    end

    // Next-state and registered-output logic; tx_n is the line level for the next cycle
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_wrap ? '0 : baud_cnt + CW'(1);
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        tx_n       = tx_q;
        byte_ready = 1'b0;

        case (state)
            IDLE: begin
                byte_ready = 1'b1;
                baud_cnt_n = '0;
                tx_n       = 1'b1;
                if (byte_valid) begin
                    state_n = START_BIT;
                    shreg_n = byte_data;
                    tx_n    = 1'b0;
                end
            end
            START_BIT: begin
                if (baud_wrap) begin
                    state_n   = DATA_BITS;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                end
            end
            DATA_BITS: begin
                if (baud_wrap) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP_BIT;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
            STOP_BIT: begin
                if (baud_wrap) begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        state_n = START_BIT;
                        shreg_n = byte_data;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/char_uart_streamer.sv
// Snapshots the ARM character array on start and streams it over UART as 8N1 frames,
// followed by CR LF, with NUL bytes shown as spaces.
module char_uart_streamer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_CHARS    = 64
) (
    input  logic           clk,
    input  logic           rst,
    char_uart_streamer_if.slave bus
);

    localparam int unsigned TOTAL = NUM_CHARS + 2;
    localparam int unsigned IW    = $clog2(TOTAL);
    localparam int unsigned SW    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    logic [7:0]    snap [NUM_CHARS];
    logic [IW-1:0] char_idx;
    logic          busy_q, done_q;
    logic          byte_valid, byte_ready, tx_line;
    logic [7:0]    byte_data, cur_byte;
    logic          accept_req, last_stop;

    assign accept_req = !busy_q && bus.start;
    assign last_stop  = busy_q && byte_ready && (char_idx == IW'(TOTAL));

    // Byte at the current index: snapshot entries, then CR, then LF
    always_comb begin
        cur_byte = ASCII_LF;
        if (char_idx < IW'(NUM_CHARS)) begin
            cur_byte = nul_to_space(snap[SW'(char_idx)]);
        end else if (char_idx == IW'(NUM_CHARS)) begin
            cur_byte = ASCII_CR;
        end
    end

    // The first byte bypasses the snapshot so the start bit begins right after the request edge
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = cur_byte;
        if (!busy_q) begin
            byte_valid = bus.start;
            byte_data  = nul_to_space(bus.charArray[0]);
        end else begin
            byte_valid = (char_idx != IW'(TOTAL));
        end
    end

    // Snapshot buffer; contents are only meaningful while busy, so it carries no reset
    always_ff @(posedge clk) begin
        if (!rst && accept_req) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                snap[i] <= bus.charArray[i];
            end
        end
    end

    // char_idx counts bytes handed to the transmitter: 0 at acceptance, 1 once entry 0 is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            char_idx <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept_req) begin
                busy_q   <= 1'b1;
                char_idx <= IW'(1);
            end else if (busy_q) begin
                if (byte_valid && byte_ready) begin
                    char_idx <= char_idx + IW'(1);
                end else if (last_stop) begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    char_idx <= '0;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx_line)
    );

    assign bus.tx   = tx_line;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_char_uart_streamer.sv
// Directed bench for char_uart_streamer with CLKS_PER_BIT=4, NUM_CHARS=64.
module tb_char_uart_streamer;

    localparam int CPB    = 4;
    localparam int NCH    = 64;
    localparam int NFR    = NCH + 2;
    localparam int FRLEN  = 10 * CPB;
    localparam int DUMP   = NFR * FRLEN;

    logic clk;
    logic rst;

    char_uart_streamer_if #(.NUM_CHARS(NCH)) bus ();

    char_uart_streamer #(
        .CLKS_PER_BIT (CPB),
        .NUM_CHARS    (NCH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_bytes  [NFR];
    logic [7:0] exp_bytes [NFR];
    int done_cycle, done_count, frame_err, busy_err;

    // Pulses start, then samples every cycle mid-bit and decodes the stream.
    // ev_kind 1: overwrite charArray with 8'h30 right after the start edge.
    // ev_kind 2: pulse start again at cycle ev_cycle.
    task automatic capture(input int ev_kind, input int ev_cycle);
        int c, f, pos, b;
        done_count = 0;
        done_cycle = -1;
        frame_err  = 0;
        busy_err   = 0;
        for (int i = 0; i < NFR; i++) rx_bytes[i] = 8'h00;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= DUMP + 6; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            c = n - 1;
            if (c < DUMP) begin
                f   = c / FRLEN;
                pos = c % FRLEN;
                if ((pos % CPB) == CPB / 2) begin
                    b = pos / CPB;
                    if (b == 0) begin
                        if (bus.tx !== 1'b0) frame_err++;
                    end else if (b == 9) begin
                        if (bus.tx !== 1'b1) frame_err++;
                    end else begin
                        rx_bytes[f][b-1] = bus.tx;
                    end
                end
            end else if (bus.tx !== 1'b1) begin
                frame_err++;
            end
            if (bus.busy !== ((n <= DUMP) ? 1'b1 : 1'b0)) busy_err++;
            if (bus.done === 1'b1) begin
                done_count++;
                done_cycle = n - 1;
            end
            if (ev_kind == 1 && n == 1) begin
                for (int i = 0; i < NCH; i++) bus.charArray[i] = 8'h30;
            end
            if (ev_kind == 2 && n == ev_cycle) bus.start = 1'b1;
            if (ev_kind == 2 && n == ev_cycle + 1) bus.start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: tx=%b busy=%b done=%b, want tx=1 busy=0 done=0",
                         i, bus.tx, bus.busy, bus.done);
            end
        end
        rst = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_start_dropped cyc%0d: tx=%b busy=%b, want tx=1 busy=0",
                         i, bus.tx, bus.busy);
            end
        end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < NCH; i++) begin
            bus.charArray[i] = 8'(8'h41 + (i % 26));
            exp_bytes[i]     = 8'(8'h41 + (i % 26));
        end
        exp_bytes[NCH]   = 8'h0D;
        exp_bytes[NCH+1] = 8'h0A;
        capture(0, 0);
        for (int f = 0; f < NFR; f++) begin
            checks++;
            if (rx_bytes[f] !== exp_bytes[f]) begin
                errors++;
                $display("FAIL full_byte%0d: got %02h want %02h", f, rx_bytes[f], exp_bytes[f]);
            end
        end
        checks++;
        if (done_count !== 1 || done_cycle !== DUMP) begin
            errors++;
            $display("FAIL full_done: count=%0d cycle=%0d, want count=1 cycle=%0d",
                     done_count, done_cycle, DUMP);
        end
        checks++;
        if (frame_err !== 0) begin
            errors++;
            $display("FAIL full_framing: bad bits=%0d want 0", frame_err);
        end
        checks++;
        if (busy_err !== 0) begin
            errors++;
            $display("FAIL full_busy: bad cycles=%0d want 0", busy_err);
        end
    endtask

    task automatic test_nul_subst();
        for (int i = 0; i < NCH; i++) bus.charArray[i] = 8'h58;
        bus.charArray[5] = 8'h00;
        capture(0, 0);
        for (int f = 0; f < NCH; f++) begin
            checks++;
            if (rx_bytes[f] !== ((f == 5) ? 8'h20 : 8'h58)) begin
                errors++;
                $display("FAIL nul_byte%0d: got %02h want %02h", f, rx_bytes[f],
                         (f == 5) ? 8'h20 : 8'h58);
            end
        end
        checks++;
        if (rx_bytes[NCH] !== 8'h0D || rx_bytes[NCH+1] !== 8'h0A) begin
            errors++;
            $display("FAIL nul_crlf: got %02h %02h want 0d 0a", rx_bytes[NCH], rx_bytes[NCH+1]);
        end
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < NCH; i++) bus.charArray[i] = 8'(8'h61 + (i % 20));
        capture(1, 0);
        for (int f = 0; f < NCH; f++) begin
            checks++;
            if (rx_bytes[f] !== 8'(8'h61 + (f % 20))) begin
                errors++;
                $display("FAIL snap_byte%0d: got %02h want %02h", f, rx_bytes[f], 8'(8'h61 + (f % 20)));
            end
        end
    endtask

    task automatic test_start_busy();
        for (int i = 0; i < NCH; i++) bus.charArray[i] = 8'(8'h21 + i);
        capture(2, 100);
        checks++;
        if (done_count !== 1 || done_cycle !== DUMP) begin
            errors++;
            $display("FAIL busy_start_done: count=%0d cycle=%0d, want count=1 cycle=%0d",
                     done_count, done_cycle, DUMP);
        end
        checks++;
        if (frame_err !== 0 || busy_err !== 0) begin
            errors++;
            $display("FAIL busy_start_frames: framing=%0d busy=%0d, want 0 0", frame_err, busy_err);
        end
        checks++;
        if (rx_bytes[0] !== 8'h21 || rx_bytes[NCH-1] !== 8'h60 || rx_bytes[NCH+1] !== 8'h0A) begin
            errors++;
            $display("FAIL busy_start_bytes: got %02h %02h %02h want 21 60 0a",
                     rx_bytes[0], rx_bytes[NCH-1], rx_bytes[NCH+1]);
        end
    endtask

    task automatic test_reset_mid();
        int dn, bad;
        for (int i = 0; i < NCH; i++) bus.charArray[i] = 8'h55;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 2; n < 500; n++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: tx=%b busy=%b done=%b, want tx=1 busy=0 done=0",
                     bus.tx, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (dn !== 0 || bad !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: done pulses=%0d bad cycles=%0d, want 0 0", dn, bad);
        end
        for (int i = 0; i < NCH; i++) bus.charArray[i] = 8'(8'h30 + (i % 10));
        capture(0, 0);
        bad = 0;
        for (int f = 0; f < NCH; f++) begin
            if (rx_bytes[f] !== 8'(8'h30 + (f % 10))) bad++;
        end
        if (rx_bytes[NCH] !== 8'h0D || rx_bytes[NCH+1] !== 8'h0A) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midrst_redump_bytes: wrong bytes=%0d want 0", bad);
        end
        checks++;
        if (done_count !== 1 || done_cycle !== DUMP || frame_err !== 0 || busy_err !== 0) begin
            errors++;
            $display("FAIL midrst_redump_timing: done=%0d@%0d framing=%0d busy=%0d, want 1@%0d 0 0",
                     done_count, done_cycle, frame_err, busy_err, DUMP);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < NCH; i++) bus.charArray[i] = 8'h00;
        test_reset();
        test_full_dump();
        test_nul_subst();
        test_snapshot();
        test_start_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_uart_streamer.md
# char_uart_streamer

Downstream consumer of the ARM top level's 64-entry character array (`charArray [63:0]`, 8 bits each). On a start pulse it snapshots the whole array and streams it out over a single UART TX line as 8N1 frames, followed by CR LF. This gives the board a serial console view of the program's text memory. It sits beside the ARM top in the board wrapper and is driven only by that top level's `charArray` output.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `NUM_CHARS`, default 64: number of array entries streamed.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a dump; sampled each cycle.
- `charArray`  in  8 × [NUM_CHARS-1:0]: character array from the ARM top.
- `tx`  out  1: UART serial output, idle high.
- `busy`  out  1: high while a dump is in progress.
- `done`  out  1: one-cycle pulse when the final stop bit has completed.

## Operation
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- **Reset values:** `tx`=1, `busy`=0, `done`=0. State is IDLE, and the char index, bit index and baud counter are all 0.
- **Accepting a request:**
  - In IDLE, `start`=1 copies all `NUM_CHARS` entries into an internal snapshot buffer on that edge.
  - The char index is set to 0 and the block moves to START_BIT.
  - `charArray` changes after that edge do not affect the dump in progress.
- **Ignored requests:** `start` while `busy` is ignored. It is not queued.
- **Byte sequence:** snapshot[0] … snapshot[NUM_CHARS-1], then 8'h0D, then 8'h0A, for NUM_CHARS+2 frames in total.
- **NUL substitution:** a snapshot byte of 8'h00 is transmitted as 8'h20 (space). No other byte is translated.
- **Frame format:** start bit 0, then 8 data bits LSB first, then stop bit 1.
- **Bit timing:** every bit is held exactly `CLKS_PER_BIT` cycles.
- **Frame spacing:** frames are back-to-back. The next start bit immediately follows the previous stop bit, with no idle gap.
- **Transitions:**
  - START_BIT goes to DATA_BITS after one bit time.
  - DATA_BITS goes to STOP_BIT after 8 bit times.
  - STOP_BIT goes to START_BIT if more bytes remain, otherwise to IDLE.
- **Completion:** on the transition to IDLE, `done` pulses for one cycle, `busy` drops and `tx` stays 1.
- **Reset mid-dump:** all registers return to reset values on the next edge and `tx` returns high. A truncated frame is acceptable. `done` is not pulsed.
- **Reset and start together:** `rst` wins and the request is dropped.

## Timing
- **Start latency:**
  - `start` is sampled at edge E0.
  - From the cycle after E0, `busy`=1 and `tx`=0 (start bit).
  - The first observable effect therefore has 1-cycle latency.
- **Total dump length:** (NUM_CHARS+2) × 10 × CLKS_PER_BIT cycles after E0.
- **Completion timing:** `done`=1 and `busy`=0 in the cycle following the last stop-bit cycle.
- **Restart:** a new `start` is accepted in the same cycle that `done` is high, because the state is already IDLE. A dump can therefore restart with zero gap.
- **Baud counter:**
  - Counts 0 … CLKS_PER_BIT-1 and wraps.
  - Width is $clog2(CLKS_PER_BIT).
  - The bit or state advances on wrap.
- **Index widths:** char index is $clog2(NUM_CHARS+2) bits; bit index is 3 bits.
- **Output registration:** `tx` is registered, with no combinational path from inputs.

## Structure
- **Shared package `uart_pkg`:**
  - State enum: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - Constants `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A, `ASCII_SPACE`=8'h20.
- **Sub-module `uart_tx_byte`:**
  - Owns the baud counter, bit index, state machine and `tx` register.
  - Interface: `byte_valid`/`byte_ready` handshake plus an 8-bit byte input.
  - `byte_ready` is high in IDLE and in the last cycle of STOP_BIT, so frames can be back-to-back.
- **Parent:** owns the snapshot buffer, char index, NUL substitution, CR/LF append, `busy` and `done`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and NUM_CHARS=64, so one frame is 40 cycles and a full dump is 2640 cycles.
1. **Reset state:** hold `rst` for 3 cycles → `tx`=1, `busy`=0, `done`=0 throughout. With `start` asserted during reset, no dump begins.
2. **Full dump:** `charArray[i]`=8'h41+(i%26), pulse `start` → UART decoder receives "ABC…" for 64 bytes, then 0D 0A. `done` pulses exactly 2640 cycles after the `start` edge.
3. **NUL substitution:** `charArray[5]`=8'h00, others 8'h58 → byte 5 decodes as 8'h20 and all others as 8'h58.
4. **Snapshot isolation:** change all of `charArray` to 8'h30 one cycle after `start` → the stream still carries the original values.
5. **Start while busy:** pulse `start` at cycle 100 of a dump → it is ignored. Exactly one `done` pulse and 66 frames result.
6. **Reset mid-dump:** assert `rst` at cycle 500 → `tx`=1 and `busy`=0 on the next edge, and no `done`. A subsequent `start` produces a clean full dump.
